// File: rtl/muldiv_seq_pkg.sv
// Shared encodings and types for the RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  typedef logic [MULDIV_XLEN-1:0] word_t;

  // OP-opcode funct7 that selects the M extension
  localparam logic [6:0] ISA_MULDIV_F7 = 7'b0000001;

  localparam logic [2:0] ISA_MULDIV_F3_MUL    = 3'd0;
  localparam logic [2:0] ISA_MULDIV_F3_MULH   = 3'd1;
  localparam logic [2:0] ISA_MULDIV_F3_MULHSU = 3'd2;
  localparam logic [2:0] ISA_MULDIV_F3_MULHU  = 3'd3;
  localparam logic [2:0] ISA_MULDIV_F3_DIV    = 3'd4;
  localparam logic [2:0] ISA_MULDIV_F3_DIVU   = 3'd5;
  localparam logic [2:0] ISA_MULDIV_F3_REM    = 3'd6;
  localparam logic [2:0] ISA_MULDIV_F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  // Two's-complement magnitude; the most negative value maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic word_t abs_word(input word_t v);
    return v[MULDIV_XLEN-1] ? (~v + word_t'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] prod_in,
  input  logic [XLEN-1:0]   mcand,
  input  logic [XLEN-1:0]   rem_in,
  input  logic [XLEN-1:0]   quo_in,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] prod_out,
  output logic [XLEN-1:0]   rem_out,
  output logic [XLEN-1:0]   quo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Compute both datapaths, then pick the one selected by the mode.
  always_comb begin
    // Multiplier sits in the low half; its LSB decides whether to add the multiplicand.
    sum     = {1'b0, prod_in[2*XLEN-1:XLEN]} + (prod_in[0] ? {1'b0, mcand} : '0);
    // Remainder < divisor, so the shifted value needs one extra bit and a non-negative
    // trial difference always fits in XLEN bits.
    shifted = {rem_in, quo_in[XLEN-1]};
    trial   = shifted - {1'b0, divisor};

    prod_out = prod_in;
    rem_out  = rem_in;
    quo_out  = quo_in;
    if (is_div) begin
      rem_out = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], ~trial[XLEN]};
    end else begin
      prod_out = {sum, prod_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with request/response handshakes.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  word_t           req_inst,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   resp_q, resp_d;

  // Accept-time decode of the offered request
  logic [2:0]      req_f3;
  logic            signed_a, signed_b;
  logic            req_sign;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic            unused_inst_bits;

  assign req_f3   = req_inst[14:12];
  assign signed_a = req_f3 inside {ISA_MULDIV_F3_MUL, ISA_MULDIV_F3_MULH, ISA_MULDIV_F3_MULHSU,
                                   ISA_MULDIV_F3_DIV, ISA_MULDIV_F3_REM};
  assign signed_b = req_f3 inside {ISA_MULDIV_F3_MUL, ISA_MULDIV_F3_MULH,
                                   ISA_MULDIV_F3_DIV, ISA_MULDIV_F3_REM};
  assign a_mag    = signed_a ? abs_word(req_a) : req_a;
  assign b_mag    = signed_b ? abs_word(req_b) : req_b;
  assign div_zero = req_f3[2] && (req_b == '0);
  assign div_ovf  = ((req_f3 == ISA_MULDIV_F3_DIV) || (req_f3 == ISA_MULDIV_F3_REM)) &&
                    (req_a == INT_MIN) && (req_b == '1);
  // Only funct3 is decoded; the caller guarantees the rest of the encoding.
  assign unused_inst_bits = ^{req_inst[31:15], req_inst[11:0]};

  // Result sign: quotient/product take a^b, remainder and MULHSU take a, unsigned ops none.
  always_comb begin
    req_sign = 1'b0;
    case (req_f3)
      ISA_MULDIV_F3_MUL, ISA_MULDIV_F3_MULH, ISA_MULDIV_F3_DIV:
        req_sign = req_a[XLEN-1] ^ req_b[XLEN-1];
      ISA_MULDIV_F3_MULHSU, ISA_MULDIV_F3_REM:
        req_sign = req_a[XLEN-1];
      default: req_sign = 1'b0;
    endcase
  end

  logic [2*XLEN-1:0] step_prod;
  logic [XLEN-1:0]   step_rem, step_quo;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div  (f3_q[2]),
    .prod_in (prod_q),
    .mcand   (opa_q),
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (opb_q),
    .prod_out(step_prod),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix-up and result selection used in FIX
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   rem_fix, quo_fix;
  logic [XLEN-1:0]   fix_result;

  assign prod_fix = sign_q ? (~prod_q + 1'b1) : prod_q;
  assign rem_fix  = sign_q ? (~rem_q + 1'b1) : rem_q;
  assign quo_fix  = sign_q ? (~quo_q + 1'b1) : quo_q;

  // Select the architectural result word for the latched funct3.
  always_comb begin
    fix_result = '0;
    case (f3_q)
      ISA_MULDIV_F3_MUL:                                           fix_result = prod_fix[XLEN-1:0];
      ISA_MULDIV_F3_MULH, ISA_MULDIV_F3_MULHSU, ISA_MULDIV_F3_MULHU:
        fix_result = prod_fix[2*XLEN-1:XLEN];
      ISA_MULDIV_F3_DIV, ISA_MULDIV_F3_DIVU:                       fix_result = quo_fix;
      default:                                                     fix_result = rem_fix;
    endcase
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    sign_d  = sign_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    resp_d  = resp_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d   = req_f3;
          sign_d = req_sign;
          opa_d  = a_mag;
          opb_d  = b_mag;
          prod_d = {{XLEN{1'b0}}, b_mag};
          rem_d  = '0;
          quo_d  = a_mag;
          cnt_d  = '0;
          if (div_zero) begin
            resp_d  = req_f3[1] ? req_a : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            resp_d  = req_f3[1] ? '0 : INT_MIN;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prod_d = step_prod;
        rem_d  = step_rem;
        quo_d  = step_quo;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        resp_d  = fix_result;
        state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush beats both a new request and a response handshake.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      sign_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      sign_q  <= sign_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      resp_q  <= resp_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_data  = resp_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus handshake/flush/reset sequences.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  word_t       req_inst;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  muldiv_seq #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_inst  (req_inst),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic word_t mk_inst(input logic [2:0] f3);
    return {ISA_MULDIV_F7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic vec_t mk_vec(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp, input int lat,
                                  input string name);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    return v;
  endfunction

  // Offer a request at a negedge and return just after the accept edge.
  task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_inst  = mk_inst(f3);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait for the response, check latency/ready/data, then complete the handshake.
  task automatic finish_op(input string name, input int exp_lat);
    int          lat;
    bit          got;
    bit          ready_seen;
    logic [31:0] exp;
    lat        = 0;
    got        = 1'b0;
    ready_seen = 1'b0;
    while (lat < 60 && !got) begin
      @(negedge clk);
      lat++;
      if (req_ready) ready_seen = 1'b1;
      if (resp_valid) got = 1'b1;
    end
    exp = exp_q.pop_front();
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: resp_valid low after %0d cycles, want high", name, lat);
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_req_ready_low"}, {31'd0, ready_seen}, 32'd0);
      chk({name, "_data"}, resp_data, exp);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk({name, "_idle_after"}, {30'd0, resp_valid, req_ready}, 32'd1);
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_q.push_back(v.exp);
    start(v.f3, v.a, v.b);
    finish_op(v.name, v.lat);
  endtask

  initial begin
    logic [31:0] held_exp;
    bit          seen;
    bit          vld_seen;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_inst   = '0;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {28'd0, req_ready, resp_valid, busy, 1'b0}, 32'h8);
    chk("reset_data", resp_data, 32'h0);
    rst = 1'b0;

    vecs.push_back(mk_vec(ISA_MULDIV_F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_neg"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "mulhsu"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_m1"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_neg"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_neg"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_negb"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 34, "rem_negb"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_DIVU,   32'd100,      32'd7,        32'd14,       34, "divu"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_REMU,   32'd100,      32'd7,        32'd2,        34, "remu"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_zero"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_REM,    32'd7,        32'd0,        32'd7,        1,  "rem_zero"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"));
    vecs.push_back(mk_vec(ISA_MULDIV_F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf"));

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-pressure: hold the result for 10 cycles while another request is offered.
    exp_q.push_back(32'd14);
    start(ISA_MULDIV_F3_DIVU, 32'd100, 32'd7);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    held_exp = exp_q.pop_front();
    chk("bp_resp_valid", {31'd0, seen}, 32'd1);
    req_inst  = mk_inst(ISA_MULDIV_F3_MUL);
    req_a     = 32'd1;
    req_b     = 32'd1;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {30'd0, resp_valid, req_ready}, 32'd2);
      chk("bp_hold_data", resp_data, held_exp);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_handshake", {29'd0, req_ready, resp_valid, busy}, 32'd4);

    // Flush at counter 15 of CALC.
    start(ISA_MULDIV_F3_MUL, 32'd5, 32'd6);
    vld_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (resp_valid) vld_seen = 1'b1;
    end
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {29'd0, req_ready, resp_valid, busy}, 32'd4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) vld_seen = 1'b1;
    end
    chk("flush_no_resp", {31'd0, vld_seen}, 32'd0);

    // Flush beats a simultaneous request in IDLE.
    @(negedge clk);
    req_inst  = mk_inst(ISA_MULDIV_F3_MUL);
    req_a     = 32'd9;
    req_b     = 32'd9;
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1 begin
      req_valid = 1'b0;
      flush     = 1'b0;
    end
    @(negedge clk);
    chk("flush_vs_req", {31'd0, busy}, 32'd0);

    run_op(mk_vec(ISA_MULDIV_F3_MUL, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush"));

    // Reset in the middle of CALC.
    start(ISA_MULDIV_F3_MULHU, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(negedge clk);
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {28'd0, req_ready, resp_valid, busy, 1'b0}, 32'h8);
    chk("rst_mid_data", resp_data, 32'h0);

    run_op(mk_vec(ISA_MULDIV_F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_after_rst"));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
